// File: rtl/interrupt_dispatch.sv
// Interrupt dispatch sequencer: stalls the CPU, pushes PC onto the stack and
// jumps to the vector of the lowest-numbered pending interrupt.
module interrupt_dispatch #(
    parameter logic [15:0] VECTOR_BASE = 16'h0040,
    parameter logic [15:0] VECTOR_STEP = 16'h0008
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic [4:0]  I_IF,
    input  logic [4:0]  I_IE,
    input  logic        I_IME,
    input  logic        I_INSTR_DONE,
    input  logic        I_HALTED,
    input  logic [15:0] I_PC,
    input  logic [15:0] I_SP,
    input  logic        I_MEM_READY,
    output logic        O_BUSY,
    output logic [15:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_DATA,
    output logic        O_MEM_WE_L,
    output logic [4:0]  O_IF_CLEAR,
    output logic        O_IME_CLEAR,
    output logic [15:0] O_PC,
    output logic        O_PC_LOAD,
    output logic [15:0] O_SP,
    output logic        O_SP_LOAD,
    output logic        O_WAKE
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT1,
        WAIT2,
        PUSH_HI,
        PUSH_LO,
        JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, sp_q;
    logic [2:0]  vec_q;
    logic        cancel_q;

    logic [4:0]  pending;
    logic        start;
    logic [2:0]  lowest_idx;
    logic [15:0] sp_minus1, sp_minus2;

    assign pending   = I_IF & I_IE;
    assign start     = I_IME & (|pending) & (I_INSTR_DONE | I_HALTED);
    assign O_WAKE    = |pending;
    assign sp_minus1 = sp_q - 16'd1;
    assign sp_minus2 = sp_q - 16'd2;

    // Bit 0 has the highest priority, so the downward scan leaves the lowest index.
    always_comb begin
        lowest_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) lowest_idx = 3'(i);
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET) begin
        if (!I_RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The vector is chosen late, as the high byte is accepted, so a source
    // that vanished after start still leaves a well-formed (cancelled) jump.
    always_ff @(posedge I_CLOCK or negedge I_RESET) begin
        if (!I_RESET) begin
            pc_q     <= 16'h0000;
            sp_q     <= 16'h0000;
            vec_q    <= 3'd0;
            cancel_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                pc_q <= I_PC;
                sp_q <= I_SP;
            end
            if (state_q == PUSH_HI && I_MEM_READY) begin
                vec_q    <= lowest_idx;
                cancel_q <= (pending == 5'b00000);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        O_BUSY      = 1'b1;
        O_MEM_ADDR  = 16'h0000;
        O_MEM_DATA  = 8'h00;
        O_MEM_WE_L  = 1'b1;
        O_IF_CLEAR  = 5'b00000;
        O_IME_CLEAR = 1'b0;
        O_PC        = 16'h0000;
        O_PC_LOAD   = 1'b0;
        O_SP        = 16'h0000;
        O_SP_LOAD   = 1'b0;

        case (state_q)
            IDLE: begin
                O_BUSY = 1'b0;
                if (start) state_d = WAIT1;
            end
            WAIT1: begin
                O_IME_CLEAR = 1'b1;
                state_d     = WAIT2;
            end
            WAIT2: begin
                state_d = PUSH_HI;
            end
            PUSH_HI: begin
                O_MEM_WE_L = 1'b0;
                O_MEM_ADDR = sp_minus1;
                O_MEM_DATA = pc_q[15:8];
                if (I_MEM_READY) state_d = PUSH_LO;
            end
            PUSH_LO: begin
                O_MEM_WE_L = 1'b0;
                O_MEM_ADDR = sp_minus2;
                O_MEM_DATA = pc_q[7:0];
                if (I_MEM_READY) state_d = JUMP;
            end
            JUMP: begin
                O_PC_LOAD = 1'b1;
                O_SP_LOAD = 1'b1;
                O_SP      = sp_minus2;
                if (!cancel_q) begin
                    O_PC       = VECTOR_BASE + VECTOR_STEP * {13'd0, vec_q};
                    O_IF_CLEAR = 5'b00001 << vec_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Scoreboard bench for interrupt_dispatch: expected stack writes, jumps and
// busy lengths are queued at stimulus time and matched by a negedge monitor.
module tb_interrupt_dispatch;

    localparam logic [15:0] BASE = 16'h0040;
    localparam logic [15:0] STEP = 16'h0008;

    logic        I_CLOCK;
    logic        I_RESET;
    logic [4:0]  I_IF;
    logic [4:0]  I_IE;
    logic        I_IME;
    logic        I_INSTR_DONE;
    logic        I_HALTED;
    logic [15:0] I_PC;
    logic [15:0] I_SP;
    logic        I_MEM_READY;
    logic        O_BUSY;
    logic [15:0] O_MEM_ADDR;
    logic [7:0]  O_MEM_DATA;
    logic        O_MEM_WE_L;
    logic [4:0]  O_IF_CLEAR;
    logic        O_IME_CLEAR;
    logic [15:0] O_PC;
    logic        O_PC_LOAD;
    logic [15:0] O_SP;
    logic        O_SP_LOAD;
    logic        O_WAKE;

    interrupt_dispatch #(.VECTOR_BASE(BASE), .VECTOR_STEP(STEP)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_IF(I_IF), .I_IE(I_IE),
        .I_IME(I_IME), .I_INSTR_DONE(I_INSTR_DONE), .I_HALTED(I_HALTED),
        .I_PC(I_PC), .I_SP(I_SP), .I_MEM_READY(I_MEM_READY),
        .O_BUSY(O_BUSY), .O_MEM_ADDR(O_MEM_ADDR), .O_MEM_DATA(O_MEM_DATA),
        .O_MEM_WE_L(O_MEM_WE_L), .O_IF_CLEAR(O_IF_CLEAR), .O_IME_CLEAR(O_IME_CLEAR),
        .O_PC(O_PC), .O_PC_LOAD(O_PC_LOAD), .O_SP(O_SP), .O_SP_LOAD(O_SP_LOAD),
        .O_WAKE(O_WAKE)
    );

    typedef struct {
        bit          is_jump;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   busy_run   = 0;
    int   idle_run   = 0;
    int   last_gap   = 0;
    int   ime_clears = 0;
    int   ime_before;

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected dispatch: two pushes, then the jump chosen from the pending set
    // seen when the high byte is accepted.
    task automatic expectDispatch(input logic [15:0] pc, input logic [15:0] sp,
                                  input logic [4:0] pend, input int busy_len);
        exp_t e;
        int   n;
        e = '{1'b0, sp - 16'd1, {8'h00, pc[15:8]}, 5'b0};
        exp_q.push_back(e);
        e = '{1'b0, sp - 16'd2, {8'h00, pc[7:0]}, 5'b0};
        exp_q.push_back(e);
        n = 0;
        while (n < 5 && !pend[n]) n++;
        if (n == 5) e = '{1'b1, 16'h0000, sp - 16'd2, 5'b00000};
        else        e = '{1'b1, BASE + STEP * 16'(n), sp - 16'd2, 5'(1 << n)};
        exp_q.push_back(e);
        busy_q.push_back(busy_len);
    endtask

    task automatic applyStimulus(input logic [4:0] iflags, input logic [4:0] ienables,
                                 input logic ime, input logic [15:0] pc, input logic [15:0] sp,
                                 input logic done_pulse, input logic halted);
        @(posedge I_CLOCK);
        #1;
        I_IF = iflags;
        I_IE = ienables;
        I_IME = ime;
        I_PC = pc;
        I_SP = sp;
        I_INSTR_DONE = done_pulse;
        I_HALTED = halted;
        if (done_pulse) begin
            @(posedge I_CLOCK);
            #1;
            I_INSTR_DONE = 1'b0;
        end
    endtask

    task automatic waitDone(input string tag);
        bit seen = 0;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge I_CLOCK);
            if (O_BUSY) seen = 1;
            else if (seen) done = 1;
        end
        checkOutput({tag, "_finished"}, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every write cycle is held against the queue head; accepted
    // writes and jumps pop it; busy runs are measured between idle cycles.
    always @(negedge I_CLOCK) begin
        if (!I_RESET) begin
            busy_run = 0;
            idle_run = 0;
        end else begin
            if (!O_MEM_WE_L) begin
                checkOutput("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("write_not_jump", {31'd0, exp_q[0].is_jump}, 32'd0);
                    checkOutput("mem_addr", {16'd0, O_MEM_ADDR}, {16'd0, exp_q[0].a});
                    checkOutput("mem_data", {24'd0, O_MEM_DATA}, {16'd0, exp_q[0].b});
                    if (I_MEM_READY) void'(exp_q.pop_front());
                end
            end
            if (O_PC_LOAD) begin
                checkOutput("jump_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("jump_not_write", {31'd0, exp_q[0].is_jump}, 32'd1);
                    checkOutput("jump_pc", {16'd0, O_PC}, {16'd0, exp_q[0].a});
                    checkOutput("jump_sp", {16'd0, O_SP}, {16'd0, exp_q[0].b});
                    checkOutput("jump_if_clear", {27'd0, O_IF_CLEAR}, {27'd0, exp_q[0].c});
                    checkOutput("jump_sp_load", {31'd0, O_SP_LOAD}, 32'd1);
                    void'(exp_q.pop_front());
                end
            end else if (O_SP_LOAD || O_IF_CLEAR != 5'b0) begin
                checkOutput("stray_strobe", {26'd0, O_SP_LOAD, O_IF_CLEAR}, 32'd0);
            end
            if (O_IME_CLEAR) ime_clears++;
            if (O_BUSY) begin
                if (busy_run == 0) last_gap = idle_run;
                busy_run++;
                idle_run = 0;
            end else begin
                if (busy_run > 0) begin
                    if (busy_q.size() != 0) checkOutput("busy_cycles", busy_run, busy_q.pop_front());
                    else checkOutput("busy_unexpected", busy_run, 0);
                    busy_run = 0;
                end
                idle_run++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        I_RESET = 1'b0;
        I_IF = 5'b0;
        I_IE = 5'b0;
        I_IME = 1'b0;
        I_INSTR_DONE = 1'b0;
        I_HALTED = 1'b0;
        I_PC = 16'h0000;
        I_SP = 16'h0000;
        I_MEM_READY = 1'b1;
        #12;
        checkOutput("reset_busy", {31'd0, O_BUSY}, 32'd0);
        checkOutput("reset_we_l", {31'd0, O_MEM_WE_L}, 32'd1);
        checkOutput("reset_strobes", {24'd0, O_PC_LOAD, O_SP_LOAD, O_IME_CLEAR, O_IF_CLEAR}, 32'd0);
        @(posedge I_CLOCK);
        #1;
        I_RESET = 1'b1;

        // V-Blank and Timer pending; V-Blank wins.
        ime_before = ime_clears;
        expectDispatch(16'h1234, 16'hFFFE, 5'b00101, 5);
        applyStimulus(5'b00101, 5'b11111, 1'b1, 16'h1234, 16'hFFFE, 1'b1, 1'b0);
        waitDone("basic");
        checkOutput("basic_ime_clear", ime_clears - ime_before, 1);

        // IE withdrawn during WAIT2 cancels the vector but not the pushes.
        expectDispatch(16'hABCD, 16'h8000, 5'b00000, 5);
        applyStimulus(5'b00100, 5'b11111, 1'b1, 16'hABCD, 16'h8000, 1'b1, 1'b0);
        @(posedge I_CLOCK);
        #1;
        I_IE = 5'b00000;
        waitDone("cancel");

        // IME off while halted: wake only.
        ime_before = ime_clears;
        applyStimulus(5'b00010, 5'b00010, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge I_CLOCK);
            checkOutput("halt_wake", {31'd0, O_WAKE}, 32'd1);
            checkOutput("halt_idle", {31'd0, O_BUSY}, 32'd0);
        end
        checkOutput("halt_no_ime_clear", ime_clears - ime_before, 0);
        I_IE = 5'b00000;
        #1;
        checkOutput("wake_ie_off", {31'd0, O_WAKE}, 32'd0);
        I_HALTED = 1'b0;

        // Memory stalls the high byte for three cycles.
        I_MEM_READY = 1'b0;
        expectDispatch(16'h5678, 16'h2000, 5'b00010, 8);
        applyStimulus(5'b00010, 5'b00010, 1'b1, 16'h5678, 16'h2000, 1'b1, 1'b0);
        repeat (5) @(posedge I_CLOCK);
        #1;
        I_MEM_READY = 1'b1;
        waitDone("stall");

        // Reset lands in PUSH_LO: only the high-byte write may appear.
        begin
            exp_t e;
            e = '{1'b0, 16'h3FFF, 16'h0011, 5'b0};
            exp_q.push_back(e);
        end
        applyStimulus(5'b00001, 5'b00001, 1'b1, 16'h1111, 16'h4000, 1'b1, 1'b0);
        repeat (3) @(posedge I_CLOCK);
        #1;
        I_RESET = 1'b0;
        #1;
        checkOutput("midreset_we_l", {31'd0, O_MEM_WE_L}, 32'd1);
        checkOutput("midreset_busy", {31'd0, O_BUSY}, 32'd0);
        checkOutput("midreset_strobes", {23'd0, O_PC_LOAD, O_SP_LOAD, O_IME_CLEAR, O_IF_CLEAR, ~O_MEM_WE_L}, 32'd0);
        repeat (2) @(posedge I_CLOCK);
        #1;
        I_RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge I_CLOCK);
            checkOutput("post_reset_idle", {31'd0, O_BUSY}, 32'd0);
        end

        // Stack pointer wraps through zero; Joypad vector.
        expectDispatch(16'hBEEF, 16'h0000, 5'b10000, 5);
        applyStimulus(5'b10000, 5'b10000, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
        waitDone("wrap");

        // HALT held through JUMP: second dispatch starts in the very next IDLE cycle.
        expectDispatch(16'h0102, 16'hC000, 5'b00011, 5);
        expectDispatch(16'h0102, 16'hC000, 5'b00011, 5);
        applyStimulus(5'b00011, 5'b00011, 1'b1, 16'h0102, 16'hC000, 1'b0, 1'b1);
        waitDone("b2b_first");
        @(posedge I_CLOCK);
        #1;
        I_HALTED = 1'b0;
        waitDone("b2b_second");
        checkOutput("b2b_idle_gap", last_gap, 1);

        repeat (3) @(negedge I_CLOCK);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("busy_drained", busy_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/interrupt_dispatch.md
INTERRUPT_DISPATCH -- requirements
Module: interrupt_dispatch

Interface
REQ-001 SHALL provide parameter VECTOR_BASE, default 16'h0040, address of the highest-priority (V-Blank) vector.
REQ-002 SHALL provide parameter VECTOR_STEP, default 16'h0008, spacing between consecutive vectors.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 I_CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-005 I_RESET  in  1  asynchronous, active-low reset.
REQ-006 I_IF  in  5  current IF flags (bit0 V-Blank ... bit4 Joypad).
REQ-007 I_IE  in  5  current IE enables, same bit order.
REQ-008 I_IME  in  1  master interrupt enable from CPU.
REQ-009 I_INSTR_DONE  in  1  CPU at an instruction boundary this cycle.
REQ-010 I_HALTED  in  1  CPU in HALT.
REQ-011 I_PC / I_SP  in  16 each  CPU program counter and stack pointer.
REQ-012 I_MEM_READY  in  1  memory accepted the current write.
REQ-013 O_BUSY  out  1  CPU stall; high in every state except IDLE.
REQ-014 O_MEM_ADDR / O_MEM_DATA / O_MEM_WE_L  out  16/8/1  stack write port (WE active low).
REQ-015 O_IF_CLEAR  out  5  one-hot (or zero) single-cycle clear strobe for the IF register.
REQ-016 O_IME_CLEAR  out  1  single-cycle strobe clearing IME.
REQ-017 O_PC / O_PC_LOAD, O_SP / O_SP_LOAD  out  16/1 each  new PC and SP with load strobes.
REQ-018 O_WAKE  out  1  combinational |(I_IF & I_IE), independent of IME, for HALT exit.

Function
REQ-019 SHALL be an FSM with states IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP.
REQ-020 Pending = I_IF & I_IE; start = I_IME & |pending & (I_INSTR_DONE | I_HALTED), sampled in IDLE only.
REQ-021 On start: IDLE->WAIT1; latch I_PC to PC_Q, I_SP to SP_Q.
REQ-022 WAIT1: O_IME_CLEAR=1 for this one cycle; WAIT1->WAIT2 unconditionally.
REQ-023 WAIT2->PUSH_HI unconditionally; no outputs besides O_BUSY.
REQ-024 PUSH_HI: O_MEM_WE_L=0, O_MEM_ADDR=SP_Q-1, O_MEM_DATA=PC_Q[15:8]; held stable until I_MEM_READY=1, then ->PUSH_LO.
REQ-025 On the PUSH_HI exit edge SHALL re-evaluate pending and latch the lowest set bit index n; if pending==0, latch cancel.
REQ-026 PUSH_LO: O_MEM_WE_L=0, O_MEM_ADDR=SP_Q-2, O_MEM_DATA=PC_Q[7:0]; held until I_MEM_READY=1, then ->JUMP.
REQ-027 JUMP (one cycle): O_PC_LOAD=1, O_SP_LOAD=1, O_SP=SP_Q-2; O_PC=VECTOR_BASE+n*VECTOR_STEP and O_IF_CLEAR=1<<n, or O_PC=16'h0000 and O_IF_CLEAR=0 if cancel; JUMP->IDLE.
REQ-028 Outside PUSH states O_MEM_WE_L=1; outside their states all strobes 0; other outputs 0.
REQ-029 SP arithmetic SHALL be modulo 2^16 (SP_Q=16'h0000 pushes to FFFF then FFFE; O_SP=FFFE; SP_Q=0001 pushes to 0000 then FFFF).
REQ-030 Minimum busy time SHALL be 5 cycles (I_MEM_READY held 1); each ready-low cycle adds one.
REQ-031 Changes to I_IF/I_IE/I_IME after start SHALL not abort dispatch; only REQ-025 sampling affects the vector.
REQ-032 A new start SHALL be evaluable in the IDLE cycle immediately after JUMP.

Reset
REQ-033 I_RESET low SHALL asynchronously force IDLE, PC_Q/SP_Q/n/cancel to 0, all strobes 0, O_MEM_WE_L=1, O_BUSY=0.
REQ-034 Reset mid-dispatch SHALL issue no IF clear, PC load, or further write; after release FSM waits in IDLE.

Verification
REQ-035 IME=1, IF=5'b00101, IE=5'b11111, PC=1234, SP=FFFE, INSTR_DONE pulse, ready=1 -> writes 12@FFFD, 34@FFFC, PC=0040, SP=FFFC, IF_CLEAR=00001, BUSY exactly 5 cycles.
REQ-036 IME=1, IF=00100, IE cleared to 0 during WAIT2 -> pushes occur, PC=0000, IF_CLEAR=0, SP decremented by 2.
REQ-037 IME=0, IF&IE=00010, HALTED=1 -> O_WAKE=1, FSM stays IDLE, no strobes.
REQ-038 I_MEM_READY low 3 cycles in PUSH_HI -> addr/data/WE stable those cycles; BUSY totals 8 cycles; final PC=0048 for IF=IE=00010.
REQ-039 Reset asserted during PUSH_LO -> immediate WE_L=1, BUSY=0, no PC/SP/IF strobe before or after release.
REQ-040 SP=0000, IF=IE=10000 -> writes FFFF then FFFE, O_SP=FFFE, PC=0060, IF_CLEAR=10000.
